// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the ALU / multiply-divide issue controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MEM    = 2'd0,
        OP_BRANCH = 2'd1,
        OP_REG    = 2'd2,
        OP_IMM    = 2'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_NOP = 4'd8
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2,
        ST_DIV  = 2'd3
    } ctrl_state_e;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam int         CNT_W     = 6;

    typedef struct packed {
        alu_ctrl_e alu_ctrl;
        cmp_ctrl_e cmp_ctrl;
        logic      cmp_en;
        md_ctrl_e  md_ctrl;
        logic      md_en;
        logic      illegal;
    } dec_t;

    localparam dec_t DEC_NONE = '{
        alu_ctrl: ALU_NOP,
        cmp_ctrl: CMP_EQ,
        cmp_en:   1'b0,
        md_ctrl:  MD_MUL,
        md_en:    1'b0,
        illegal:  1'b0
    };

    // RV32I funct3 map shared by reg-reg and reg-imm forms; alt selects SUB/SRA.
    function automatic dec_t rv32_arith(input logic [2:0] funct3, input logic alt);
        dec_t d;
        d = DEC_NONE;
        case (funct3)
            3'd0: d.alu_ctrl = alt ? ALU_SUB : ALU_ADD;
            3'd1: d.alu_ctrl = ALU_SLL;
            3'd2: begin
                d.cmp_ctrl = CMP_LT;
                d.cmp_en   = 1'b1;
            end
            3'd3: begin
                d.cmp_ctrl = CMP_LTU;
                d.cmp_en   = 1'b1;
            end
            3'd4: d.alu_ctrl = ALU_XOR;
            3'd5: d.alu_ctrl = alt ? ALU_SRA : ALU_SRL;
            3'd6: d.alu_ctrl = ALU_OR;
            default: d.alu_ctrl = ALU_AND;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Purely combinational field decode: alu_op/funct3/funct7 to ALU, compare
// and multiply-divide controls plus an illegal flag.
module alu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output dec_t       dec
);

    always_comb begin
        dec = DEC_NONE;
        case (alu_op_e'(alu_op))
            OP_MEM: dec.alu_ctrl = ALU_ADD;
            OP_BRANCH: begin
                dec.cmp_en = 1'b1;
                case (funct3)
                    3'd0: dec.cmp_ctrl = CMP_EQ;
                    3'd1: dec.cmp_ctrl = CMP_NE;
                    3'd4: dec.cmp_ctrl = CMP_LT;
                    3'd5: dec.cmp_ctrl = CMP_GE;
                    3'd6: dec.cmp_ctrl = CMP_LTU;
                    3'd7: dec.cmp_ctrl = CMP_GEU;
                    default: begin
                        dec.cmp_en  = 1'b0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                if (funct7 == F7_MULDIV) begin
                    dec.md_en   = 1'b1;
                    dec.md_ctrl = md_ctrl_e'(funct3);
                end else if (funct7 == F7_BASE) begin
                    dec = rv32_arith(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    dec = rv32_arith(funct3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                // Only the shift-right immediate form uses funct7 to pick SRL/SRA.
                if (funct3 == 3'd5 && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec = rv32_arith(funct3, (funct3 == 3'd5) && (funct7 == F7_ALT));
                end
            end
            default: dec = DEC_NONE;
        endcase
    end

endmodule

// File: rtl/mdu_alu_controller.sv
// Issue controller: registers decoded controls, holds them until consumed,
// and sequences multi-cycle multiply/divide occupancy with a down-counter.
module mdu_alu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctrl,
    output logic [2:0] cmp_ctrl,
    output logic       cmp_en,
    output logic [2:0] md_ctrl,
    output logic       md_en,
    output logic       md_start,
    output logic       illegal
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    dec_t             dec;
    dec_t             res_q;
    dec_t             op_q;
    dec_t             shown;
    ctrl_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic             md_start_q;
    logic             can_take;
    logic             accept;

    alu_decode u_decode (
        .alu_op (alu_op),
        .funct7 (funct7),
        .funct3 (funct3),
        .dec    (dec)
    );

    // HOLD only takes a new request in the same cycle its result is consumed.
    assign can_take = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
    assign in_ready = !rst && !flush && can_take;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
            res_q       <= DEC_NONE;
            op_q        <= DEC_NONE;
        end else begin
            md_start_q <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (dec.md_en) begin
                            op_q        <= dec;
                            res_q       <= DEC_NONE;
                            out_valid_q <= 1'b0;
                            md_start_q  <= 1'b1;
                            if (dec.md_ctrl >= MD_DIV) begin
                                state <= ST_DIV;
                                cnt   <= DIV_LOAD;
                            end else begin
                                state <= ST_MUL;
                                cnt   <= MUL_LOAD;
                            end
                        end else begin
                            res_q       <= dec;
                            out_valid_q <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        res_q       <= DEC_NONE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    // The held M-op controls become visible once the count drains.
                    if (cnt == '0) begin
                        state       <= ST_HOLD;
                        res_q       <= op_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A flush cycle blanks the result side immediately, not just from the next cycle.
    assign shown     = flush ? DEC_NONE : res_q;
    assign out_valid = out_valid_q && !flush;
    assign md_start  = md_start_q && !flush;
    assign alu_ctrl  = shown.alu_ctrl;
    assign cmp_ctrl  = shown.cmp_ctrl;
    assign cmp_en    = shown.cmp_en;
    assign md_ctrl   = shown.md_ctrl;
    assign md_en     = shown.md_en;
    assign illegal   = shown.illegal;

endmodule

// File: tb/tb_mdu_alu_controller.sv
// Bench for mdu_alu_controller: transaction-level model compared every cycle,
// plus directed sequences with literal expectations.
module tb_mdu_alu_controller;

    localparam int MUL_C = 2;
    localparam int DIV_C = 32;
    localparam logic [12:0] NONE13 = {4'd8, 9'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'd0;
    logic [6:0] funct7 = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_ctrl;
    logic [2:0] cmp_ctrl;
    logic       cmp_en;
    logic [2:0] md_ctrl;
    logic       md_en;
    logic       md_start;
    logic       illegal;

    int tests = 0;
    int failures = 0;
    bit check_en = 1'b0;

    mdu_alu_controller #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .cmp_ctrl  (cmp_ctrl),
        .cmp_en    (cmp_en),
        .md_ctrl   (md_ctrl),
        .md_en     (md_en),
        .md_start  (md_start),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Single place where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the next rising edge, drives new inputs, then lets them settle.
    task automatic applyStimulus(input logic r, input logic fl, input logic v,
                                 input logic [1:0] op, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; flush = fl; in_valid = v;
        alu_op = op; funct7 = f7; funct3 = f3; out_ready = ordy;
        #1;
    endtask

    // Field decode written straight from the instruction rules.
    // Layout: {alu_ctrl[4], cmp_ctrl[3], cmp_en, md_ctrl[3], md_en, illegal}.
    function automatic logic [12:0] model_decode(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] a; logic [2:0] c; logic ce; logic [2:0] m; logic me; logic il;
        a = 4'd8; c = 3'd0; ce = 1'b0; m = 3'd0; me = 1'b0; il = 1'b0;
        if (op == 2'd0) begin
            a = 4'd0;
        end else if (op == 2'd1) begin
            if (f3 == 3'd2 || f3 == 3'd3) il = 1'b1;
            else begin
                ce = 1'b1;
                case (f3)
                    3'd0: c = 3'd0;
                    3'd1: c = 3'd1;
                    3'd4: c = 3'd2;
                    3'd5: c = 3'd3;
                    3'd6: c = 3'd4;
                    default: c = 3'd5;
                endcase
            end
        end else if (op == 2'd2 && f7 == 7'h01) begin
            me = 1'b1; m = f3;
        end else if ((op == 2'd2 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ||
                     (op == 2'd3 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
            il = 1'b1;
        end else begin
            case (f3)
                3'd0: a = (op == 2'd2 && f7 == 7'h20) ? 4'd1 : 4'd0;
                3'd1: a = 4'd5;
                3'd2: begin ce = 1'b1; c = 3'd2; end
                3'd3: begin ce = 1'b1; c = 3'd4; end
                3'd4: a = 4'd2;
                3'd5: a = (f7 == 7'h20) ? 4'd7 : 4'd6;
                3'd6: a = 4'd3;
                default: a = 4'd4;
            endcase
        end
        return {a, c, ce, m, me, il};
    endfunction

    // Transaction model: at most one outstanding op, visible from ready_at until taken.
    bit          pend = 1'b0;
    int          cyc = 0;
    int          ready_at = 0;
    int          start_at = -1;
    logic [12:0] pend_f = NONE13;

    always @(negedge clk) begin
        if (check_en) begin
            logic        exp_ov, exp_ir, exp_ms;
            logic [12:0] f, nf;
            exp_ov = pend && (cyc >= ready_at) && !flush;
            exp_ir = !rst && !flush && (!pend || ((cyc >= ready_at) && out_ready));
            exp_ms = pend && (cyc == start_at) && !flush;
            f = exp_ov ? pend_f : NONE13;
            checkOutput($sformatf("cycle%0d", cyc),
                        {16'd0, out_valid, in_ready, md_start, alu_ctrl, cmp_ctrl, cmp_en, md_ctrl, md_en, illegal},
                        {16'd0, exp_ov, exp_ir, exp_ms, f});
            if (rst || flush) begin
                pend = 1'b0;
            end else begin
                if (pend && (cyc >= ready_at) && out_ready) pend = 1'b0;
                if (in_valid && exp_ir) begin
                    nf = model_decode(alu_op, funct7, funct3);
                    pend   = 1'b1;
                    pend_f = nf;
                    if (nf[1]) begin
                        ready_at = cyc + ((nf[4:2] >= 3'd4) ? DIV_C : MUL_C) + 1;
                        start_at = cyc + 1;
                    end else begin
                        ready_at = cyc + 1;
                        start_at = -1;
                    end
                end
            end
            cyc++;
        end
    end

    logic [11:0] tbl [15] = '{
        {2'd3, 7'h00, 3'd5}, {2'd3, 7'h20, 3'd5}, {2'd3, 7'h10, 3'd5}, {2'd2, 7'h00, 3'd2},
        {2'd3, 7'h00, 3'd3}, {2'd1, 7'h00, 3'd2}, {2'd2, 7'h20, 3'd1}, {2'd2, 7'h01, 3'd3},
        {2'd2, 7'h00, 3'd1}, {2'd2, 7'h01, 3'd7}, {2'd1, 7'h00, 3'd7}, {2'd2, 7'h00, 3'd6},
        {2'd3, 7'h00, 3'd0}, {2'd1, 7'h00, 3'd1}, {2'd0, 7'h00, 3'd0}
    };

    initial begin
        int lat, ir_low, ms_cnt, guard;
        logic [11:0] e;

        // Reset state
        applyStimulus(1, 0, 0, 2'd0, 7'h00, 3'd0, 0);
        check_en = 1'b1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl, 8);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 0);
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Back-to-back SUB then XOR with the consumer always ready
        applyStimulus(0, 0, 1, 2'd2, 7'h20, 3'd0, 1);
        applyStimulus(0, 0, 1, 2'd2, 7'h20, 3'd0, 1);
        checkOutput("sub_out_valid", out_valid, 1);
        checkOutput("sub_alu_ctrl", alu_ctrl, 1);
        checkOutput("sub_in_ready", in_ready, 1);
        applyStimulus(0, 0, 1, 2'd2, 7'h00, 3'd4, 1);
        checkOutput("sub2_alu_ctrl", alu_ctrl, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("xor_alu_ctrl", alu_ctrl, 2);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 0);
        checkOutput("drain_out_valid", out_valid, 0);

        // Branch LTU held through a three-cycle stall
        applyStimulus(0, 0, 1, 2'd1, 7'h00, 3'd6, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 2'd0, 7'h00, 3'd0, 0);
            checkOutput("br_hold", {out_valid, in_ready, alu_ctrl, cmp_ctrl, cmp_en},
                        {1'b1, 1'b0, 4'd8, 3'd4, 1'b1});
        end
        applyStimulus(0, 0, 1, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("load_add", {out_valid, alu_ctrl, cmp_en}, {1'b1, 4'd0, 1'b0});
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 0);

        // DIV occupancy and latency
        applyStimulus(0, 0, 1, 2'd2, 7'h01, 3'd4, 0);
        lat = 0; ir_low = 0; ms_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(0, 0, 1, 2'd0, 7'h00, 3'd0, 1);
            if (md_start) ms_cnt++;
            if (out_valid) begin
                lat = k;
                checkOutput("div_md_ctrl", {md_en, md_ctrl}, {1'b1, 3'd4});
                break;
            end
            if (!in_ready) ir_low++;
        end
        checkOutput("div_latency", lat, 33);
        checkOutput("div_in_ready_low", ir_low, 32);
        checkOutput("div_md_start_count", ms_cnt, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 0);

        // MULH flushed on its completion cycle
        applyStimulus(0, 0, 1, 2'd2, 7'h01, 3'd1, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("mul_md_start", md_start, 1);
        applyStimulus(0, 1, 1, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("flush_in_ready", in_ready, 0);
        checkOutput("flush_md_start", md_start, 0);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("after_flush", {in_ready, out_valid}, {1'b1, 1'b0});
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);

        // Flush in HOLD overrides a simultaneous accept
        applyStimulus(0, 0, 1, 2'd2, 7'h00, 3'd7, 1);
        applyStimulus(0, 1, 1, 2'd3, 7'h00, 3'd6, 1);
        checkOutput("hold_flush_out", {out_valid, alu_ctrl}, {1'b0, 4'd8});
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("hold_flush_after", {out_valid, in_ready}, {1'b0, 1'b1});

        // Undecodable funct7
        applyStimulus(0, 0, 1, 2'd2, 7'h7F, 3'd0, 0);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 0);
        checkOutput("illegal_fields", {out_valid, illegal, alu_ctrl, cmp_en, md_en},
                    {1'b1, 1'b1, 4'd8, 1'b0, 1'b0});
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);

        // Mixed decode table, issued as fast as the controller accepts
        for (int i = 0; i < 15; i++) begin
            e = tbl[i];
            applyStimulus(0, 0, 1, e[11:10], e[9:3], e[2:0], 1);
            guard = 0;
            while (!in_ready && guard < 60) begin
                applyStimulus(0, 0, 1, e[11:10], e[9:3], e[2:0], 1);
                guard++;
            end
            if (guard >= 60) checkOutput("table_wait_in_ready", in_ready, 1);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);

        // Reset while a DIVU sits at count 10
        applyStimulus(0, 0, 1, 2'd2, 7'h01, 3'd5, 1);
        for (int k = 1; k <= 21; k++) applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        applyStimulus(1, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("div_rst_in_ready", in_ready, 0);
        applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
        checkOutput("div_rst_outputs", {out_valid, md_start, alu_ctrl, cmp_ctrl, cmp_en, md_ctrl, md_en, illegal, in_ready},
                    {1'b0, 1'b0, 4'd8, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        ms_cnt = 0; lat = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 0, 0, 2'd0, 7'h00, 3'd0, 1);
            if (md_start) ms_cnt++;
            if (out_valid) lat++;
        end
        checkOutput("div_rst_no_md_start", ms_cnt, 0);
        checkOutput("div_rst_no_out_valid", lat, 0);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mdu_alu_controller.md
MDU_ALU_CONTROLLER -- requirements
Module: mdu_alu_controller

Interface
REQ-001 Parameter MUL_CYCLES, default 2, meaning cycles a multiply occupies the unit (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 32, meaning cycles a divide/remainder occupies the unit (legal range 1..63).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  decode request present; in_ready  out  1  controller accepts request this cycle.
REQ-006 alu_op  in  2  0 load/store, 1 branch, 2 reg-reg arithmetic, 3 reg-imm arithmetic.
REQ-007 funct7  in  7 and funct3  in  3  instruction fields.
REQ-008 flush  in  1  discard any held or in-flight operation.
REQ-009 out_valid  out  1 and out_ready  in  1  result-side handshake.
REQ-010 alu_ctrl  out  4  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 NOP=8.
REQ-011 cmp_ctrl  out  3  EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5; cmp_en  out  1  cmp_ctrl meaningful.
REQ-012 md_ctrl  out  3  MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7; md_en  out  1  md_ctrl meaningful.
REQ-013 md_start  out  1  one-cycle pulse to datapath multiplier/divider; illegal  out  1  undecodable fields.

Function
REQ-014 Transfer occurs on in_valid&&in_ready; result consumed on out_valid&&out_ready.
REQ-015 Non-M ops decoded per alu_op/funct3/funct7 (alu_op 0 -> ADD; 1 -> cmp by funct3 0,1,4,5,6,7; 2/3 -> standard RV32I map, funct3 2/3 -> cmp LT/LTU with cmp_en=1, alu_ctrl=NOP).
REQ-016 M-op: alu_op=2 and funct7=7'h01; md_ctrl=funct3, md_en=1, alu_ctrl=NOP.
REQ-017 Illegal: alu_op=1 with funct3 2/3, or alu_op=2 funct7 not in {00,20,01}, or funct7=20 with funct3 not 0/5, or alu_op=3 funct3=5 funct7 not 00/20; outputs alu_ctrl=NOP, cmp_en=0, md_en=0, illegal=1, still returns out_valid.
REQ-018 FSM states IDLE, HOLD, MUL, DIV.
REQ-019 IDLE: in_ready=1; accepted non-M op -> HOLD, outputs registered, out_valid=1 next cycle (latency 1).
REQ-020 HOLD: out_valid=1, outputs stable; if out_ready: accept new request same cycle (in_ready=out_ready) -> HOLD/MUL/DIV per new op, else -> IDLE.
REQ-021 Accepted M-op -> MUL (md_ctrl 0..3) or DIV (4..7); md_start=1 exactly first cycle in that state; in_ready=0; counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1.
REQ-022 MUL/DIV: counter decrements each cycle; at 0 -> HOLD, so out_valid rises MUL_CYCLES+1 / DIV_CYCLES+1 cycles after acceptance.
REQ-023 Counter width 6 bits; never wraps below 0.
REQ-024 flush: next state IDLE, out_valid=0, md_start=0, in_ready=0 during flush cycle; flush overrides simultaneous accept and completion.
REQ-025 out_valid held with stable outputs until out_ready (no drop while stalled).
REQ-026 Outputs when out_valid=0: alu_ctrl=NOP, others 0.

Reset
REQ-027 rst: state IDLE, counter 0, out_valid=0, md_start=0, alu_ctrl=NOP, cmp_ctrl=0, cmp_en=0, md_ctrl=0, md_en=0, illegal=0; in_ready=0 during rst, 1 the cycle after.
REQ-028 rst mid-MUL/DIV abandons operation; no md_start or out_valid follows.

Structure
REQ-029 alu_op, alu_ctrl, cmp_ctrl, md_ctrl enums and the FSM state type live in shared package cpu_ctrl_pkg.
REQ-030 Combinational decode is sub-module alu_decode (fields in, alu_ctrl/cmp/md/illegal out); this block adds registers, FSM, counter.

Verification
REQ-031 alu_op=2 funct7=20 funct3=0, out_ready=1 -> next cycle out_valid=1 alu_ctrl=1 (SUB), back-to-back accept each cycle.
REQ-032 alu_op=1 funct3=6 -> cmp_ctrl=4 cmp_en=1 alu_ctrl=8; out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-033 alu_op=2 funct7=01 funct3=4, DIV_CYCLES=32 -> md_start one cycle, in_ready=0 for 32 cycles, out_valid on cycle 33 with md_ctrl=4.
REQ-034 MUL funct3=1 accepted, flush on 2nd cycle -> out_valid never asserts, in_ready=1 two cycles later.
REQ-035 alu_op=2 funct7=7F funct3=0 -> illegal=1 alu_ctrl=8 out_valid=1.
REQ-036 rst asserted during DIV count 10 -> all outputs at reset values next cycle, no later md_start/out_valid.
